// File: rtl/level_sequencer.sv
// Game-flow controller: level sequencing, intro/hold timing, play timer and lives.
// Optional pause via `LEVEL_PAUSE_EN (P key toggles a frozen PLAY).
module level_sequencer #(
  parameter int unsigned NUM_LEVELS   = 4,
  parameter int unsigned INTRO_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 90,
  parameter int unsigned TIME_LIMIT   = 1800,
  parameter int unsigned LIVES        = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [63:0] keycode,
  input  logic        success,
  input  logic [4:0]  tbl_startx,
  input  logic [4:0]  tbl_starty,
  input  logic [4:0]  tbl_goalx,
  input  logic [4:0]  tbl_goaly,
  output logic [2:0]  level_idx,
  output logic [4:0]  startx,
  output logic [4:0]  starty,
  output logic [4:0]  goalx,
  output logic [4:0]  goaly,
  output logic        player_reset,
  output logic        freeze,
  output logic [10:0] frames_left,
  output logic [2:0]  lives_left,
  output logic [2:0]  state,
  output logic        game_won,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INTRO = 3'd2,
    PLAY  = 3'd3,
    WIN   = 3'd4,
    FAIL  = 3'd5,
    DONE  = 3'd6,
    OVER  = 3'd7
  } state_t;

  localparam logic [7:0]  KEY_ENTER  = 8'h28;
  localparam logic [7:0]  KEY_ESC    = 8'h29;
  localparam logic [10:0] INTRO_M1   = 11'(INTRO_FRAMES - 1);
  localparam logic [10:0] HOLD_M1    = 11'(HOLD_FRAMES - 1);
  localparam logic [10:0] TIME_INIT  = 11'(TIME_LIMIT);
  localparam logic        TIMED      = (TIME_LIMIT != 0);
  localparam logic [2:0]  LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

  state_t      state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [4:0]  startx_q, startx_d, starty_q, starty_d;
  logic [4:0]  goalx_q, goalx_d, goaly_q, goaly_d;
  logic [10:0] frames_q, frames_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  lives_q, lives_d;
  logic        player_reset_q, game_won_q, game_over_q;
  logic        enter_prev_q;
  logic        enter_now, esc_now, enter_edge;

`ifdef LEVEL_PAUSE_EN
  localparam logic [7:0] KEY_P = 8'h13;
  logic p_now, p_prev_q, p_edge;
  logic paused_q, paused_d;
`endif

  always_comb begin
    enter_now = 1'b0;
    esc_now   = 1'b0;
`ifdef LEVEL_PAUSE_EN
    p_now     = 1'b0;
`endif
    for (int unsigned i = 0; i < 8; i++) begin
      if (keycode[i*8 +: 8] == KEY_ENTER) enter_now = 1'b1;
      if (keycode[i*8 +: 8] == KEY_ESC)   esc_now   = 1'b1;
`ifdef LEVEL_PAUSE_EN
      if (keycode[i*8 +: 8] == KEY_P)     p_now     = 1'b1;
`endif
    end
  end

  assign enter_edge = enter_now && !enter_prev_q;
`ifdef LEVEL_PAUSE_EN
  assign p_edge = p_now && !p_prev_q;
`endif

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    startx_d = startx_q;
    starty_d = starty_q;
    goalx_d  = goalx_q;
    goaly_d  = goaly_q;
    frames_d = frames_q;
    cnt_d    = cnt_q;
    lives_d  = lives_q;
`ifdef LEVEL_PAUSE_EN
    paused_d = paused_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enter_edge) begin
          level_d = '0;
          lives_d = LIVES_INIT;
          state_d = LOAD;
        end
      end
      LOAD: begin
        startx_d = tbl_startx;
        starty_d = tbl_starty;
        goalx_d  = tbl_goalx;
        goaly_d  = tbl_goaly;
        cnt_d    = INTRO_M1;
        state_d  = INTRO;
      end
      INTRO: begin
        if (cnt_q == '0) begin
          frames_d = TIME_INIT;
          state_d  = PLAY;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      PLAY: begin
        if (esc_now) begin
          state_d = IDLE;
`ifdef LEVEL_PAUSE_EN
        end else if (p_edge) begin
          paused_d = !paused_q;
        end else if (paused_q) begin
          frames_d = frames_q;
`endif
        end else if (success) begin
          cnt_d   = HOLD_M1;
          state_d = WIN;
        end else if (TIMED && frames_q == 11'd1) begin
          frames_d = '0;
          lives_d  = (lives_q == '0) ? '0 : lives_q - 3'd1;
          cnt_d    = HOLD_M1;
          state_d  = FAIL;
        end else if (TIMED) begin
          frames_d = frames_q - 11'd1;
        end
      end
      WIN: begin
        if (cnt_q == '0) begin
          if (level_q == LAST_LEVEL) begin
            state_d = DONE;
          end else begin
            level_d = level_q + 3'd1;
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      FAIL: begin
        if (cnt_q == '0) state_d = (lives_q == '0) ? OVER : LOAD;
        else             cnt_d   = cnt_q - 11'd1;
      end
      DONE, OVER: begin
        if (enter_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef LEVEL_PAUSE_EN
    if (state_d != PLAY) paused_d = 1'b0;
`endif
  end

  // Flag outputs are registered from the next state so they move with state.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      level_q        <= '0;
      startx_q       <= '0;
      starty_q       <= '0;
      goalx_q        <= '0;
      goaly_q        <= '0;
      frames_q       <= '0;
      cnt_q          <= '0;
      lives_q        <= LIVES_INIT;
      player_reset_q <= 1'b1;
      game_won_q     <= 1'b0;
      game_over_q    <= 1'b0;
      enter_prev_q   <= 1'b0;
`ifdef LEVEL_PAUSE_EN
      p_prev_q       <= 1'b0;
      paused_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      startx_q       <= startx_d;
      starty_q       <= starty_d;
      goalx_q        <= goalx_d;
      goaly_q        <= goaly_d;
      frames_q       <= frames_d;
      cnt_q          <= cnt_d;
      lives_q        <= lives_d;
      player_reset_q <= (state_d != PLAY);
      game_won_q     <= (state_d == DONE);
      game_over_q    <= (state_d == OVER);
      enter_prev_q   <= enter_now;
`ifdef LEVEL_PAUSE_EN
      p_prev_q       <= p_now;
      paused_q       <= paused_d;
`endif
    end
  end

`ifdef LEVEL_PAUSE_EN
  assign freeze = paused_q;
`else
  assign freeze = 1'b0;
`endif

  assign state        = state_q;
  assign level_idx    = level_q;
  assign startx       = startx_q;
  assign starty       = starty_q;
  assign goalx        = goalx_q;
  assign goaly        = goaly_q;
  assign frames_left  = frames_q;
  assign lives_left   = lives_q;
  assign player_reset = player_reset_q;
  assign game_won     = game_won_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: level flow, timeout/lives, Esc, reset, pause.
module tb_level_sequencer;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [63:0] keycode;
  logic        success;
  logic [4:0]  tbl_startx, tbl_starty, tbl_goalx, tbl_goaly;
  logic [2:0]  level_idx;
  logic [4:0]  startx, starty, goalx, goaly;
  logic        player_reset, freeze;
  logic [10:0] frames_left;
  logic [2:0]  lives_left, state;
  logic        game_won, game_over;

  int tests  = 0;
  int errors = 0;

  localparam logic [63:0] K_ENTER = 64'h0000_0000_2800_0000;
  localparam logic [63:0] K_ESC   = 64'h2900_0000_0000_0000;
  localparam logic [63:0] K_P     = 64'h0000_0000_0000_0013;

  level_sequencer #(
    .NUM_LEVELS  (2),
    .INTRO_FRAMES(4),
    .HOLD_FRAMES (3),
    .TIME_LIMIT  (10),
    .LIVES       (2)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .success     (success),
    .tbl_startx  (tbl_startx),
    .tbl_starty  (tbl_starty),
    .tbl_goalx   (tbl_goalx),
    .tbl_goaly   (tbl_goaly),
    .level_idx   (level_idx),
    .startx      (startx),
    .starty      (starty),
    .goalx       (goalx),
    .goaly       (goaly),
    .player_reset(player_reset),
    .freeze      (freeze),
    .frames_left (frames_left),
    .lives_left  (lives_left),
    .state       (state),
    .game_won    (game_won),
    .game_over   (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  // Level table: level0 (6,6)->(20,3), level1 (1,2)->(30,29)
  always_comb begin
    if (level_idx == 3'd0) begin
      tbl_startx = 5'd6; tbl_starty = 5'd6; tbl_goalx = 5'd20; tbl_goaly = 5'd3;
    end else begin
      tbl_startx = 5'd1; tbl_starty = 5'd2; tbl_goalx = 5'd30; tbl_goaly = 5'd29;
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_level"}, 32'(level_idx), 0);
    chk({tag, "_startx"}, 32'(startx), 0);
    chk({tag, "_goaly"}, 32'(goaly), 0);
    chk({tag, "_frames"}, 32'(frames_left), 0);
    chk({tag, "_lives"}, 32'(lives_left), 2);
    chk({tag, "_preset"}, 32'(player_reset), 1);
    chk({tag, "_freeze"}, 32'(freeze), 0);
    chk({tag, "_won"}, 32'(game_won), 0);
    chk({tag, "_over"}, 32'(game_over), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; keycode = '0; success = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");

    // Enter held 5 frames: single LOAD, 4 INTRO frames, then PLAY
    Reset = 1'b0; keycode = K_ENTER;
    tick(); chk("load_state", 32'(state), 1); chk("load_preset", 32'(player_reset), 1);
    tick(); chk("intro_state", 32'(state), 2);
    chk("l0_startx", 32'(startx), 6); chk("l0_starty", 32'(starty), 6);
    chk("l0_goalx", 32'(goalx), 20); chk("l0_goaly", 32'(goaly), 3);
    repeat (3) begin tick(); chk("intro_hold", 32'(state), 2); end
    keycode = '0;
    tick(); chk("play_state", 32'(state), 3); chk("play_frames", 32'(frames_left), 10);
    chk("play_preset", 32'(player_reset), 0); chk("play_freeze", 32'(freeze), 0);

    // success at play frame 5
    repeat (4) tick();
    chk("count_down", 32'(frames_left), 6);
    success = 1'b1; tick(); success = 1'b0;
    chk("win_state", 32'(state), 4); chk("win_frames", 32'(frames_left), 6);
    chk("win_preset", 32'(player_reset), 1);
    repeat (2) begin tick(); chk("win_hold", 32'(state), 4); end
    tick(); chk("reload_state", 32'(state), 1); chk("reload_level", 32'(level_idx), 1);
    tick(); chk("l1_state", 32'(state), 2);
    chk("l1_startx", 32'(startx), 1); chk("l1_starty", 32'(starty), 2);
    chk("l1_goalx", 32'(goalx), 30); chk("l1_goaly", 32'(goaly), 29);
    repeat (3) tick();
    tick(); chk("l1_play", 32'(state), 3);
    success = 1'b1; tick(); success = 1'b0;
    chk("l1_win", 32'(state), 4);
    repeat (2) tick();
    tick(); chk("done_state", 32'(state), 6); chk("done_won", 32'(game_won), 1);
    chk("done_over", 32'(game_over), 0);
    keycode = K_ENTER; tick();
    chk("done_exit", 32'(state), 0); chk("done_clear", 32'(game_won), 0);
    tick(); chk("enter_level", 32'(state), 0);

    // Two timeouts lead to OVER
    keycode = '0; tick();
    keycode = K_ENTER; tick(); keycode = '0;
    chk("g2_load", 32'(state), 1); chk("g2_level", 32'(level_idx), 0);
    chk("g2_lives", 32'(lives_left), 2);
    tick(); chk("g2_startx", 32'(startx), 6);
    repeat (3) tick();
    tick(); chk("g2_play", 32'(state), 3);
    repeat (9) tick();
    chk("g2_last", 32'(frames_left), 1); chk("g2_last_st", 32'(state), 3);
    tick(); chk("to1_state", 32'(state), 5); chk("to1_frames", 32'(frames_left), 0);
    chk("to1_lives", 32'(lives_left), 1);
    repeat (2) begin tick(); chk("fail_hold", 32'(state), 5); end
    tick(); chk("retry_load", 32'(state), 1); chk("retry_level", 32'(level_idx), 0);
    tick(); repeat (3) tick();
    tick(); chk("retry_play", 32'(state), 3); chk("retry_frames", 32'(frames_left), 10);
    repeat (10) tick();
    chk("to2_state", 32'(state), 5); chk("to2_lives", 32'(lives_left), 0);
    repeat (2) tick();
    tick(); chk("over_state", 32'(state), 7); chk("over_flag", 32'(game_over), 1);
    chk("over_won", 32'(game_won), 0);
    keycode = K_ENTER; tick();
    chk("over_exit", 32'(state), 0); chk("over_clear", 32'(game_over), 0);

    // success coinciding with frames_left==1 wins
    keycode = '0; tick();
    keycode = K_ENTER; tick(); keycode = '0;
    chk("g3_lives", 32'(lives_left), 2);
    tick(); repeat (3) tick(); tick();
    chk("g3_play", 32'(state), 3);
    repeat (9) tick();
    success = 1'b1; tick(); success = 1'b0;
    chk("tie_state", 32'(state), 4); chk("tie_frames", 32'(frames_left), 1);
    chk("tie_lives", 32'(lives_left), 2);

    // Reset mid-WIN
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_reset_vals("midwin");

    // P key and Esc in PLAY
    keycode = K_ENTER; tick(); keycode = '0;
    tick(); repeat (3) tick(); tick();
    chk("g4_play", 32'(state), 3);
`ifdef LEVEL_PAUSE_EN
    repeat (3) tick();
    chk("pre_pause", 32'(frames_left), 7);
    keycode = K_P; tick(); keycode = '0;
    chk("pause_freeze", 32'(freeze), 1); chk("pause_frames", 32'(frames_left), 7);
    success = 1'b1;
    repeat (20) tick();
    success = 1'b0;
    chk("paused_frames", 32'(frames_left), 7); chk("paused_state", 32'(state), 3);
    chk("paused_preset", 32'(player_reset), 0); chk("paused_freeze", 32'(freeze), 1);
    keycode = K_P; tick(); keycode = '0;
    chk("resume_freeze", 32'(freeze), 0); chk("resume_frames", 32'(frames_left), 7);
    tick(); chk("resume_count", 32'(frames_left), 6);
`else
    keycode = K_P; tick(); keycode = '0;
    chk("p_ignored_frz", 32'(freeze), 0); chk("p_ignored_cnt", 32'(frames_left), 9);
`endif
    keycode = K_ESC; tick(); keycode = '0;
    chk("esc_state", 32'(state), 0); chk("esc_preset", 32'(player_reset), 1);
    chk("esc_freeze", 32'(freeze), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
Game-flow controller for the maze player datapath. It sequences levels from an external level table and holds the player block in reset during spawn, intro and result phases. It latches start and goal tile coordinates, runs a per-level frame timer and tracks lives. It sits between keyboard keycode decode and the player block, and ticks once per frame on frame_clk.

Parameters:
NUM_LEVELS, 4, number of table levels (1..8)
INTRO_FRAMES, 60, frames held in INTRO before play (1..2047)
HOLD_FRAMES, 90, frames held in WIN/FAIL before next step (1..2047)
TIME_LIMIT, 1800, play frames allowed per level (0 = no limit, max 2047)
LIVES, 3, lives at game start (1..7)

Ports:
frame_clk  in  1  frame-rate clock; all logic on its rising edge
Reset  in  1  synchronous, active-high
keycode  in  64  eight USB HID key slots, 8 bits each
success  in  1  goal-reached flag from player block; sticky until player reset
tbl_startx  in  5  start tile X for level_idx (combinational table)
tbl_starty  in  5  start tile Y
tbl_goalx  in  5  goal tile X
tbl_goaly  in  5  goal tile Y
level_idx  out  3  current level index, drives table address
startx, starty  out  5 each  latched spawn tile
goalx, goaly  out  5 each  latched goal tile
player_reset  out  1  drives player block Reset
freeze  out  1  ORed into player coll_next upstream
frames_left  out  11  remaining play frames
lives_left  out  3  remaining lives
state  out  3  IDLE=0 LOAD=1 INTRO=2 PLAY=3 WIN=4 FAIL=5 DONE=6 OVER=7
game_won  out  1  high in DONE
game_over  out  1  high in OVER

Behaviour:
- Reset: state=IDLE, level_idx=0, start/goal regs=0, frames_left=0, lives_left=LIVES, player_reset=1, freeze=0, game_won=0, game_over=0.
- Key detect: a key is pressed when any of the 8 slots equals its code (Enter 0x28, Esc 0x29, P 0x13).
- Enter and P act on rising edge only: pressed this frame and not pressed last frame. One previous-press register per key.
- player_reset=1 in every state except PLAY. It is registered, so it changes in the same frame as the state change.
- IDLE: wait for Enter edge, then set level_idx=0, lives_left=LIVES, go to LOAD.
- LOAD: lasts 1 frame. Latch tbl_* into startx/starty/goalx/goaly, load counter=INTRO_FRAMES-1, go to INTRO.
- INTRO: decrement the counter each frame. When it reads 0, go to PLAY and set frames_left=TIME_LIMIT. Total INTRO length is exactly INTRO_FRAMES frames.
- PLAY: evaluated in this priority order each frame:
  1. Esc pressed: go to IDLE.
  2. success=1: go to WIN.
  3. TIME_LIMIT!=0 and frames_left==1: set frames_left=0, go to FAIL.
  4. Otherwise, if TIME_LIMIT!=0, decrement frames_left.
  success in the same frame as timeout yields WIN.
- WIN: hold HOLD_FRAMES frames. Then if level_idx==NUM_LEVELS-1, go to DONE. Otherwise increment level_idx and go to LOAD.
- FAIL: decrement lives_left on entry (saturates at 0). Hold HOLD_FRAMES frames. Then if lives_left==0, go to OVER. Otherwise go to LOAD with the same level_idx.
- DONE and OVER: game_won or game_over held high. Enter edge goes to IDLE and clears both flags.
- Hold counter: 11 bits, one shared counter for INTRO, WIN and FAIL.
- Latched coordinates change only in LOAD.
- Reset in any state, including mid-hold, returns to the reset values on the next edge.
- frames_left holds its value outside PLAY and shows the last value reached.

Optional Feature:
LEVEL_PAUSE_EN
- Defined: adds a PAUSE state, encoded as state=PLAY with freeze=1, and an internal paused bit.
- A P edge in PLAY toggles paused.
- While paused: freeze=1, frames_left frozen, success and timeout ignored, player_reset stays 0.
- Esc still goes to IDLE and clears paused. Leaving PLAY clears paused.
- Undefined: freeze tied to 0 and the P key is ignored.

Test Plan:
- Params INTRO=4, HOLD=3, TIME=10, LEVELS=2, LIVES=2. Reset, then Enter held 5 frames: exactly one LOAD, then 4 INTRO frames, then PLAY. frames_left=10 at PLAY entry. player_reset falls at PLAY entry.
- Table level0 start=(6,6) goal=(20,3). success pulsed at play frame 5: WIN for 3 frames, level_idx becomes 1, LOAD re-latches the level1 table. A level1 success then leads to DONE with game_won=1.
- No success for 10 play frames: FAIL with frames_left=0 and lives_left=1. Same level reloads. A second timeout leads to OVER with game_over=1. Enter edge returns to IDLE.
- success and frames_left==1 in the same frame: WIN, lives unchanged.
- Esc in PLAY returns to IDLE next frame. Reset asserted mid-WIN gives all reset values next frame.
- With LEVEL_PAUSE_EN: P edge at frames_left=7 sets freeze=1; frames_left stays 7 for 20 frames and success is ignored. A second P edge resumes counting down from 7.
